uart_prog_loader: RTL and testbench

//  Consumes bytes from the UART receiver (data + valid strobe) and loads them into CPU program memory.

---
 rtl/uart_prog_loader.sv | 176 +++++++++++++++++
 tb/tb_uart_prog_loader.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_prog_loader.sv
// rtl/uart_prog_loader.sv - UART framed program loader (SYNC, LEN, data, optional CSUM)
// Optional trailing checksum byte enabled by defining LOADER_CHECKSUM_EN.
module uart_prog_loader #(
  parameter int                    DATA_WIDTH        = 8,
  parameter int                    ADDR_WIDTH        = 5,
  parameter logic [DATA_WIDTH-1:0] SYNC_BYTE         = 8'hA5,
  parameter int                    TIMEOUT_CYCLES    = 10420,
  parameter int                    TIMEOUT_CNT_WIDTH = 14
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic [DATA_WIDTH-1:0] rx_data_i,
  input  logic                  rx_valid_strb_i,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  output logic                  cpu_halt_o,
  output logic                  load_done_strb_o,
  output logic                  load_err_o
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LEN  = 3'd1;
  localparam logic [2:0] S_DATA = 3'd2;
  localparam logic [2:0] S_DONE = 3'd3;
`ifdef LOADER_CHECKSUM_EN
  localparam logic [2:0] S_CSUM = 3'd4;
`endif

  localparam logic [TIMEOUT_CNT_WIDTH-1:0] TMO_LAST = TIMEOUT_CNT_WIDTH'(TIMEOUT_CYCLES - 1);
  localparam logic [31:0]                  MAX_LEN  = 32'(2 ** ADDR_WIDTH);

  logic [2:0]                   state_q, state_d;
  logic [ADDR_WIDTH:0]          len_q, len_d;
  logic [ADDR_WIDTH:0]          cnt_q, cnt_d;
  logic [TIMEOUT_CNT_WIDTH-1:0] tmo_q, tmo_d;
  logic                         we_q, we_d;
  logic [ADDR_WIDTH-1:0]        addr_q, addr_d;
  logic [DATA_WIDTH-1:0]        wdata_q, wdata_d;
  logic                         halt_q, halt_d;
  logic                         done_q, done_d;
  logic                         err_q, err_d;
`ifdef LOADER_CHECKSUM_EN
  logic [DATA_WIDTH-1:0]        csum_q, csum_d;
`endif
  logic                         fail;
  logic                         in_frame;
  logic                         len_bad;
  logic                         last_byte;

  assign in_frame  = (state_q != S_IDLE) && (state_q != S_DONE);
  assign len_bad   = (rx_data_i == '0) || (32'(rx_data_i) > MAX_LEN);
  assign last_byte = (cnt_q + 1'b1) == len_q;

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    tmo_d   = '0;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    halt_d  = halt_q;
    done_d  = 1'b0;
    err_d   = err_q;
`ifdef LOADER_CHECKSUM_EN
    csum_d  = csum_q;
`endif
    fail    = 1'b0;

    case (state_q)
      // DONE behaves like IDLE for an incoming byte so back-to-back frames work
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (state_q == S_DONE) begin
          done_d = 1'b1;
          halt_d = 1'b0;
        end
        if (rx_valid_strb_i && (rx_data_i == SYNC_BYTE)) begin
          state_d = S_LEN;
          halt_d  = 1'b1;
          err_d   = 1'b0;
        end
      end
      S_LEN: begin
        if (rx_valid_strb_i) begin
          if (len_bad) begin
            fail = 1'b1;
          end else begin
            len_d   = rx_data_i[ADDR_WIDTH:0];
            cnt_d   = '0;
`ifdef LOADER_CHECKSUM_EN
            csum_d  = '0;
`endif
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (rx_valid_strb_i) begin
          we_d    = 1'b1;
          addr_d  = cnt_q[ADDR_WIDTH-1:0];
          wdata_d = rx_data_i;
          cnt_d   = cnt_q + 1'b1;
`ifdef LOADER_CHECKSUM_EN
          csum_d  = csum_q + rx_data_i;
          if (last_byte) state_d = S_CSUM;
`else
          if (last_byte) state_d = S_DONE;
`endif
        end
      end
`ifdef LOADER_CHECKSUM_EN
      S_CSUM: begin
        if (rx_valid_strb_i) begin
          if (rx_data_i == csum_q) state_d = S_DONE;
          else                     fail    = 1'b1;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase

    // Inter-byte watchdog: only runs while a frame is open
    if (in_frame && !rx_valid_strb_i) begin
      if (tmo_q == TMO_LAST) fail  = 1'b1;
      else                   tmo_d = tmo_q + 1'b1;
    end

    if (fail) begin
      err_d   = 1'b1;
      halt_d  = 1'b1;
      state_d = S_IDLE;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
      tmo_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      halt_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      halt_q  <= halt_d;
      done_q  <= done_d;
      err_q   <= err_d;
`ifdef LOADER_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

  assign mem_we_o         = we_q;
  assign mem_addr_o       = addr_q;
  assign mem_wdata_o      = wdata_q;
  assign cpu_halt_o       = halt_q;
  assign load_done_strb_o = done_q;
  assign load_err_o       = err_q;

endmodule

// File: tb/tb_uart_prog_loader.sv
// tb/tb_uart_prog_loader.sv - self-checking bench for uart_prog_loader
// Follows LOADER_CHECKSUM_EN the same way as the design build.
module tb_uart_prog_loader;

  localparam int TMO = 40;
  localparam logic [7:0] SYNC = 8'hA5;

  logic       clk_i = 1'b0;
  logic       reset_i;
  logic [7:0] rx_data;
  logic       strb;
  logic       mem_we_o;
  logic [4:0] mem_addr_o;
  logic [7:0] mem_wdata_o;
  logic       cpu_halt_o;
  logic       load_done_strb_o;
  logic       load_err_o;

  uart_prog_loader #(
    .DATA_WIDTH(8), .ADDR_WIDTH(5), .SYNC_BYTE(8'hA5),
    .TIMEOUT_CYCLES(TMO), .TIMEOUT_CNT_WIDTH(14)
  ) dut (
    .clk_i(clk_i), .reset_i(reset_i), .rx_data_i(rx_data), .rx_valid_strb_i(strb),
    .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .cpu_halt_o(cpu_halt_o), .load_done_strb_o(load_done_strb_o), .load_err_o(load_err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct { logic [4:0] a; logic [7:0] d; } wr_t;
  typedef struct { logic [7:0] b[10]; int n; int wr; int done; logic err; logic halt; } vec_t;

  wr_t  act_wr[$];
  wr_t  exp_wr[$];
  int   act_done;
  int   n_chk = 0;
  int   n_fail = 0;
  vec_t vt[9];

  always @(negedge clk_i) begin
    if (mem_we_o) act_wr.push_back('{a: mem_addr_o, d: mem_wdata_o});
    if (load_done_strb_o) act_done++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk_i); #1; end
  endtask

  task automatic strobe(input logic [7:0] b);
    rx_data = b;
    strb    = 1'b1;
    @(posedge clk_i); #1;
    strb    = 1'b0;
  endtask

  task automatic rst();
    reset_i = 1'b1;
    strb    = 1'b0;
    rx_data = 8'h00;
    idle(2);
    reset_i = 1'b0;
    act_wr.delete();
    act_done = 0;
  endtask

  function automatic vec_t mk(input logic [79:0] bytes, input int n, input int wr,
                              input int done, input logic err, input logic halt);
    vec_t v;
    for (int k = 0; k < 10; k++) v.b[k] = (k < n) ? bytes[8*(n-1-k) +: 8] : 8'h00;
    v.n = n; v.wr = wr; v.done = done; v.err = err; v.halt = halt;
    return v;
  endfunction

  // Frame-level parser of a byte stream: what the memory and status should end up as
  function automatic void model(input logic [7:0] s[$], output int done,
                                output logic err, output logic halt);
    int i = 0;
    int len;
    logic [7:0] sum;
    done = 0; err = 1'b0; halt = 1'b0;
    exp_wr.delete();
    while (i < s.size()) begin
      if (s[i] != SYNC) begin i++; continue; end
      halt = 1'b1; err = 1'b0; i++;
      if (i >= s.size()) break;
      len = int'(s[i]); i++;
      if (len == 0 || len > 32) begin err = 1'b1; continue; end
      sum = 8'h00;
      for (int k = 0; k < len && i < s.size(); k++) begin
        exp_wr.push_back('{a: 5'(k), d: s[i]});
        sum = sum + s[i];
        i++;
      end
`ifdef LOADER_CHECKSUM_EN
      if (i >= s.size()) break;
      if (s[i] != sum) begin err = 1'b1; i++; continue; end
      i++;
`endif
      done++;
      halt = 1'b0;
    end
  endfunction

  initial begin
    logic [7:0] stream[$];
    logic [7:0] b, sum;
    int   kind, len, nvec, e_done;
    logic e_err, e_halt;

`ifdef LOADER_CHECKSUM_EN
    vt[0] = mk(80'hA5_03_11_22_33_66, 6, 3, 1, 1'b0, 1'b0);
    vt[1] = mk(80'hA5_02_01_02_FF, 5, 2, 0, 1'b1, 1'b1);
    vt[2] = mk(80'hA5_02_01_02_FF_A5_01_07_07, 9, 3, 1, 1'b0, 1'b0);
    vt[6] = mk(80'hA5_01_A5_A5, 4, 1, 1, 1'b0, 1'b0);
    vt[7] = mk(80'hA5_02_F0_20_10, 5, 2, 1, 1'b0, 1'b0);
    vt[8] = mk(80'hA5_21_A5_01_33_33, 6, 1, 1, 1'b0, 1'b0);
`else
    vt[0] = mk(80'hA5_03_11_22_33, 5, 3, 1, 1'b0, 1'b0);
    vt[1] = mk(80'hA5_02_01_02_FF, 5, 2, 1, 1'b0, 1'b0);
    vt[2] = mk(80'hA5_02_01_02_FF_A5_01_07, 8, 3, 2, 1'b0, 1'b0);
    vt[6] = mk(80'hA5_01_A5, 3, 1, 1, 1'b0, 1'b0);
    vt[7] = mk(80'hA5_02_F0_20, 4, 2, 1, 1'b0, 1'b0);
    vt[8] = mk(80'hA5_21_A5_01_33, 5, 1, 1, 1'b0, 1'b0);
`endif
    vt[3] = mk(80'h00_5A_FF, 3, 0, 0, 1'b0, 1'b0);
    vt[4] = mk(80'hA5_00, 2, 0, 0, 1'b1, 1'b1);
    vt[5] = mk(80'hA5_21, 2, 0, 0, 1'b1, 1'b1);
    nvec = 9;

    reset_i = 1'b1; strb = 1'b0; rx_data = 8'h00; act_done = 0;
    #1;
    chk("rst_we", mem_we_o, 0);
    chk("rst_addr", mem_addr_o, 0);
    chk("rst_wdata", mem_wdata_o, 0);
    chk("rst_halt", cpu_halt_o, 0);
    chk("rst_done", load_done_strb_o, 0);
    chk("rst_err", load_err_o, 0);

    for (int v = 0; v < nvec; v++) begin
      rst();
      for (int j = 0; j < vt[v].n; j++) begin strobe(vt[v].b[j]); idle(1); end
      idle(3);
      chk($sformatf("vec%0d_writes", v), act_wr.size(), vt[v].wr);
      chk($sformatf("vec%0d_done", v), act_done, vt[v].done);
      chk($sformatf("vec%0d_err", v), load_err_o, vt[v].err);
      chk($sformatf("vec%0d_halt", v), cpu_halt_o, vt[v].halt);
    end

    // Cycle-accurate write/halt/done timing of a good frame
    rst();
    strobe(8'hA5);
    chk("t1_halt_after_sync", cpu_halt_o, 1);
    idle(1); strobe(8'h03); idle(1);
    strobe(8'h11);
    chk("t1_we0", mem_we_o, 1);
    chk("t1_addr0", mem_addr_o, 0);
    chk("t1_wdata0", mem_wdata_o, 8'h11);
    idle(1);
    chk("t1_we_low", mem_we_o, 0);
    chk("t1_addr_hold", mem_addr_o, 0);
    strobe(8'h22); idle(1);
    strobe(8'h33);
    chk("t1_addr2", mem_addr_o, 2);
    chk("t1_wdata2", mem_wdata_o, 8'h33);
`ifdef LOADER_CHECKSUM_EN
    idle(1); strobe(8'h66);
`endif
    chk("t1_halt_in_done", cpu_halt_o, 1);
    chk("t1_no_done_yet", load_done_strb_o, 0);
    idle(1);
    chk("t1_done_pulse", load_done_strb_o, 1);
    chk("t1_halt_released", cpu_halt_o, 0);
    chk("t1_err", load_err_o, 0);
    idle(1);
    chk("t1_done_one_cycle", load_done_strb_o, 0);

    // SYNC arriving in the DONE cycle opens the next frame
    rst();
    strobe(8'hA5); strobe(8'h02); strobe(8'h10); strobe(8'h20);
`ifdef LOADER_CHECKSUM_EN
    strobe(8'h30);
`endif
    strobe(8'hA5);
    chk("t6_done_with_sync", load_done_strb_o, 1);
    chk("t6_halt_resync", cpu_halt_o, 1);
    strobe(8'h01); strobe(8'h07);
`ifdef LOADER_CHECKSUM_EN
    strobe(8'h07);
`endif
    idle(3);
    chk("t6_done_cnt", act_done, 2);
    chk("t6_writes", act_wr.size(), 3);
    if (act_wr.size() == 3) begin
      chk("t6_last_addr", act_wr[2].a, 0);
      chk("t6_last_data", act_wr[2].d, 8'h07);
    end
    chk("t6_halt", cpu_halt_o, 0);

    // Inter-byte timeout
    rst();
    strobe(8'hA5); strobe(8'h04); strobe(8'hAA);
    idle(TMO - 1);
    chk("t4_err_before_tmo", load_err_o, 0);
    idle(1);
    chk("t4_err_at_tmo", load_err_o, 1);
    chk("t4_halt", cpu_halt_o, 1);
    chk("t4_writes", act_wr.size(), 1);
    if (act_wr.size() == 1) chk("t4_wdata", act_wr[0].d, 8'hAA);
    act_wr.delete(); act_done = 0;
    strobe(8'hA5); strobe(8'h01); strobe(8'h55);
`ifdef LOADER_CHECKSUM_EN
    strobe(8'h55);
`endif
    idle(3);
    chk("t4_reload_done", act_done, 1);
    chk("t4_reload_err", load_err_o, 0);
    chk("t4_reload_halt", cpu_halt_o, 0);

    // Asynchronous reset in the middle of DATA
    rst();
    strobe(8'hA5); strobe(8'h03); strobe(8'h11);
    #2 reset_i = 1'b1;
    #1;
    chk("t5_we_async", mem_we_o, 0);
    chk("t5_halt_async", cpu_halt_o, 0);
    chk("t5_wdata_async", mem_wdata_o, 0);
    @(posedge clk_i); #1;
    reset_i = 1'b0;
    act_wr.delete();
    strobe(8'h22); idle(2);
    chk("t5_no_write", act_wr.size(), 0);
    chk("t5_halt_idle", cpu_halt_o, 0);

    // Randomised byte stream against the frame parser
    rst();
    for (int f = 0; f < 30; f++) begin
      kind = $urandom_range(0, 3);
      if (kind == 0) begin
        repeat ($urandom_range(1, 3)) begin
          b = 8'($urandom);
          if (b == SYNC) b = 8'h00;
          stream.push_back(b);
        end
      end else if (kind == 1) begin
        stream.push_back(SYNC);
        stream.push_back(($urandom_range(0, 1) == 1) ? 8'h00 : 8'($urandom_range(33, 255)));
      end else begin
        len = (f == 7) ? 32 : $urandom_range(1, 8);
        stream.push_back(SYNC);
        stream.push_back(8'(len));
        sum = 8'h00;
        for (int k = 0; k < len; k++) begin
          b = 8'($urandom);
          sum = sum + b;
          stream.push_back(b);
        end
`ifdef LOADER_CHECKSUM_EN
        stream.push_back((kind == 3) ? (sum ^ 8'($urandom_range(1, 255))) : sum);
`endif
      end
    end
    model(stream, e_done, e_err, e_halt);
    foreach (stream[i]) begin
      strobe(stream[i]);
      idle($urandom_range(0, 3));
    end
    idle(4);
    chk("rnd_writes", act_wr.size(), exp_wr.size());
    for (int i = 0; i < exp_wr.size() && i < act_wr.size(); i++) begin
      chk($sformatf("rnd_addr%0d", i), act_wr[i].a, exp_wr[i].a);
      chk($sformatf("rnd_data%0d", i), act_wr[i].d, exp_wr[i].d);
    end
    chk("rnd_done", act_done, e_done);
    chk("rnd_err", load_err_o, e_err);
    chk("rnd_halt", cpu_halt_o, e_halt);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
